recipe_gen: RTL and testbench
=============================

// Module: recipe_gen
// PURPOSE
//  Parametrised cake-recipe generator: builds a NUM_LAYERS-deep colour recipe plus cherry top.
//  Colours come from an internal seedable LFSR; no random ROM is used.
//  Adds start/busy/done handshake, out-of-range colour rejection, optional no-adjacent-repeat
//  mode and a bounded retry fallback. Sits between game FSM and cake renderer/score checker.
// PARAMETERS
//  NUM_LAYERS   5      cake layers excl. cherry (>=1)
//  CLR_W        3      bits per colour code
//  NUM_COLOURS  6      valid codes 0..NUM_COLOURS-1 (<= 2**CLR_W)
//  CHERRY_CODE  3'b111 code written to top slot
//  LFSR_W       8      LFSR width
//  TAPS         8'hB8  feedback mask; fb = ^(lfsr & TAPS)
//  SEED         8'd56  LFSR reset value
//  NO_REPEAT    1      1: a layer may not equal the layer below it
//  MAX_RETRY    7      consecutive rejects before fallback (>=1)
// PORTS
//  clk           in   1                      clock, rising edge
//  resetn        in   1                      synchronous, active-low reset
//  start         in   1                      request new recipe (sampled in IDLE/DONE)
//  seed_ld       in   1                      load seed_in into LFSR
//  seed_in       in   LFSR_W                 seed value
//  busy          out  1                      high while in GEN
//  done          out  1                      1-cycle pulse on GEN->DONE
//  recipe_valid  out  1                      high in DONE; recipe stable
//  layer_count   out  clog2(NUM_LAYERS+1)    layers accepted so far
//  recipe        out  (NUM_LAYERS+1)*CLR_W   {cherry, layer1, ..., layerN}; layer1 below cherry
// BEHAVIOUR
//  Reset: state=IDLE, lfsr=SEED, all layers=0, cherry slot=0, busy=done=recipe_valid=0, layer_count=0.
//  LFSR: advances every cycle in every state: lfsr <= {lfsr[LFSR_W-2:0], fb}.
//   seed_ld beats the advance: lfsr <= seed_in, or 1 if seed_in==0 (lock-up guard).
//  FSM:
//   IDLE -start-> GEN: clear layers, cherry slot, layer_count, retry cnt.
//   GEN: candidate c = lfsr[CLR_W-1:0] (pre-advance value), checked every cycle.
//    Reject c if c>=NUM_COLOURS, or NO_REPEAT && layer_count>0 && c==prev layer. Reject increments retry.
//    When retry==MAX_RETRY, accept fallback f=(prev+1)%NUM_COLOURS this cycle (prev=0 if first layer).
//    On accept: layer[layer_count+1]<=c|f; layer_count++; retry<=0.
//    On final accept (layer_count becomes NUM_LAYERS): write cherry=CHERRY_CODE, go to DONE,
//     and pulse done in that same transition cycle.
//   DONE: recipe_valid=1; recipe held. start -> GEN, clearing as from IDLE; recipe_valid drops next cycle.
//  start during GEN is ignored. seed_ld in GEN is legal and takes effect next cycle.
//  Latency: start@t -> done@t+NUM_LAYERS+k, where k = total rejected cycles.
//   Worst case is NUM_LAYERS*(MAX_RETRY+1) cycles.
//  Mid-operation resetn=0 aborts immediately to reset values; no partial recipe survives.
//  Layers not yet generated read 0 in recipe while busy.
// TESTING
//  1 Reset: resetn=0 2 cycles -> recipe=0, busy=done=recipe_valid=0, layer_count=0.
//  2 Defaults, seed_ld seed 0x38 @t, start @t+1.
//    -> LFSR 0x71,0xE2,0xC4,0x89,0x12 gives layers 1,2,4,1,2.
//    -> done @t+6, recipe={7,1,2,4,1,2}.
//  3 Rejection, NUM_COLOURS=6: seed forcing candidates 7,6,3.
//    -> two GEN cycles with no accept, then layer1=3.
//  4 NO_REPEAT=1, MAX_RETRY=2: candidates 4,4,4,4 after layer1=4.
//    -> 2 rejects, then layer2=5 (fallback).
//  5 Handshake: start held throughout GEN -> no restart; done pulses once.
//    start in DONE -> recipe_valid low next cycle, new GEN.
//  6 resetn=0 at layer_count=3 -> next cycle IDLE, recipe=0, lfsr=SEED.
//    seed_ld with seed_in=0 -> lfsr=1.

Source files
------------

// File: rtl/recipe_gen.sv
// Cake-recipe generator: fills NUM_LAYERS colour slots from a free-running LFSR,
// rejecting out-of-range or repeated colours, then caps the stack with a cherry code.
module recipe_gen #(
    parameter int unsigned NUM_LAYERS  = 5,
    parameter int unsigned CLR_W       = 3,
    parameter int unsigned NUM_COLOURS = 6,
    parameter logic [CLR_W-1:0] CHERRY_CODE = 3'b111,
    parameter int unsigned LFSR_W      = 8,
    parameter logic [LFSR_W-1:0] TAPS  = 8'hB8,
    parameter logic [LFSR_W-1:0] SEED  = 8'd56,
    parameter bit          NO_REPEAT   = 1'b1,
    parameter int unsigned MAX_RETRY   = 7,
    localparam int unsigned CNT_W      = $clog2(NUM_LAYERS + 1),
    localparam int unsigned RETRY_W    = $clog2(MAX_RETRY + 1),
    localparam int unsigned RECIPE_W   = (NUM_LAYERS + 1) * CLR_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                seed_ld,
    input  logic [LFSR_W-1:0]   seed_in,
    output logic                busy,
    output logic                done,
    output logic                recipe_valid,
    output logic [CNT_W-1:0]    layer_count,
    output logic [RECIPE_W-1:0] recipe
);

    typedef enum logic [1:0] {StIdle, StGen, StDone} state_t;

    state_t             state;
    logic [LFSR_W-1:0]  lfsr;
    logic [RETRY_W-1:0] retry;
    logic [CLR_W-1:0]   cherry;
    logic [CLR_W-1:0]   layers [NUM_LAYERS];

    logic               lfsr_fb;
    logic [CLR_W-1:0]   cand;
    logic [CLR_W-1:0]   prev;
    logic [CLR_W-1:0]   fallback;
    logic [CLR_W-1:0]   new_layer;
    logic               cand_ok;
    logic               accept;

    always_comb begin
        lfsr_fb = ^(lfsr & TAPS);
        cand    = lfsr[CLR_W-1:0];
        prev    = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (layer_count == CNT_W'(i + 1)) prev = layers[i];
        end
        cand_ok   = (32'(cand) < NUM_COLOURS) &&
                    !(NO_REPEAT && (layer_count != '0) && (cand == prev));
        fallback  = CLR_W'((32'(prev) + 32'd1) % NUM_COLOURS);
        // A valid candidate always wins; the fallback only replaces a reject once
        // the retry budget is exhausted.
        accept    = cand_ok || (retry == RETRY_W'(MAX_RETRY));
        new_layer = cand_ok ? cand : fallback;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= StIdle;
            lfsr         <= SEED;
            retry        <= '0;
            cherry       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            recipe_valid <= 1'b0;
            layer_count  <= '0;
            for (int i = 0; i < NUM_LAYERS; i++) layers[i] <= '0;
        end else begin
            if (seed_ld) begin
                lfsr <= (seed_in == '0) ? LFSR_W'(1) : seed_in;
            end else begin
                lfsr <= {lfsr[LFSR_W-2:0], lfsr_fb};
            end
            done <= 1'b0;

            case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state        <= StGen;
                        busy         <= 1'b1;
                        recipe_valid <= 1'b0;
                        layer_count  <= '0;
                        retry        <= '0;
                        cherry       <= '0;
                        for (int i = 0; i < NUM_LAYERS; i++) layers[i] <= '0;
                    end
                end
                StGen: begin
                    if (accept) begin
                        for (int i = 0; i < NUM_LAYERS; i++) begin
                            if (layer_count == CNT_W'(i)) layers[i] <= new_layer;
                        end
                        layer_count <= layer_count + CNT_W'(1);
                        retry       <= '0;
                        if (layer_count == CNT_W'(NUM_LAYERS - 1)) begin
                            state        <= StDone;
                            cherry       <= CHERRY_CODE;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            recipe_valid <= 1'b1;
                        end
                    end else begin
                        retry <= retry + RETRY_W'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Cherry in the top slot, layer 1 directly beneath it, layer N at the LSBs.
    always_comb begin
        recipe = '0;
        recipe[NUM_LAYERS*CLR_W +: CLR_W] = cherry;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            recipe[(NUM_LAYERS-1-i)*CLR_W +: CLR_W] = layers[i];
        end
    end

endmodule

// File: tb/tb_recipe_gen.sv
// Bench for recipe_gen: directed scenarios plus randomized traffic, all outputs compared
// every cycle against an integer-level reference model.
module tb_recipe_gen;

    localparam int N      = 5;
    localparam int CW     = 3;
    localparam int NC     = 6;
    localparam int MR     = 2;
    localparam int SEED   = 56;
    localparam int TAPS   = 'hB8;
    localparam int BUDGET = N * (MR + 1) + 10;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        seed_ld = 1'b0;
    logic [7:0]  seed_in = 8'd0;
    logic        busy;
    logic        done;
    logic        recipe_valid;
    logic [2:0]  layer_count;
    logic [17:0] recipe;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state, plain integers.
    int m_lfsr, m_phase, m_cnt, m_retry, m_cherry;
    int m_busy, m_done, m_valid;
    int m_lay [1:N];

    recipe_gen #(.MAX_RETRY(MR)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .seed_ld      (seed_ld),
        .seed_in      (seed_in),
        .busy         (busy),
        .done         (done),
        .recipe_valid (recipe_valid),
        .layer_count  (layer_count),
        .recipe       (recipe)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int lfsr_next(input int cur);
        int fb;
        fb = $countones(cur & TAPS) % 2;
        return ((cur * 2) + fb) % 256;
    endfunction

    function automatic int model_recipe();
        int r;
        r = m_cherry;
        for (int i = 1; i <= N; i++) r = r * 8 + m_lay[i];
        return r;
    endfunction

    task automatic model_step();
        int cur, c, prev, ok;
        if (!resetn) begin
            m_lfsr = SEED; m_phase = 0; m_cnt = 0; m_retry = 0; m_cherry = 0;
            m_busy = 0; m_done = 0; m_valid = 0;
            for (int i = 1; i <= N; i++) m_lay[i] = 0;
            return;
        end
        cur = m_lfsr;
        if (seed_ld) m_lfsr = (seed_in == 8'd0) ? 1 : int'(seed_in);
        else m_lfsr = lfsr_next(cur);
        m_done = 0;
        if (m_phase != 1 && start) begin
            m_phase = 1; m_busy = 1; m_valid = 0;
            m_cnt = 0; m_retry = 0; m_cherry = 0;
            for (int i = 1; i <= N; i++) m_lay[i] = 0;
        end else if (m_phase == 1) begin
            c    = cur % 8;
            prev = (m_cnt > 0) ? m_lay[m_cnt] : 0;
            ok   = (c < NC) && !(m_cnt > 0 && c == prev);
            if (ok || m_retry == MR) begin
                m_cnt++;
                m_lay[m_cnt] = ok ? c : (prev + 1) % NC;
                m_retry = 0;
                if (m_cnt == N) begin
                    m_cherry = 7; m_phase = 2;
                    m_busy = 0; m_done = 1; m_valid = 1;
                end
            end else begin
                m_retry++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("done", 32'(done), 32'(m_done));
        check_eq("recipe_valid", 32'(recipe_valid), 32'(m_valid));
        check_eq("layer_count", 32'(layer_count), 32'(m_cnt));
        check_eq("recipe", 32'(recipe), 32'(model_recipe()));
    endtask

    // Ticks until recipe_valid rises or the budget runs out; returns cycles used.
    task automatic run_to_done(output int k);
        k = 0;
        while (k < BUDGET) begin
            tick();
            k++;
            if (recipe_valid) break;
        end
    endtask

    initial begin
        int k, pulses;

        // Reset held two cycles.
        resetn = 1'b0;
        tick();
        tick();
        check_eq("rst_recipe", 32'(recipe), 32'd0);
        check_eq("rst_count", 32'(layer_count), 32'd0);

        // Seed 0x38 then start: layers 1,2,4,1,2, done five edges after start.
        resetn  = 1'b1;
        seed_ld = 1'b1;
        seed_in = 8'h38;
        tick();
        seed_ld = 1'b0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        run_to_done(k);
        check_eq("seed38_latency", 32'(k), 32'd5);
        check_eq("seed38_recipe", 32'(recipe), 32'(18'o712412));

        // Restart from DONE with start held through GEN.
        start = 1'b1;
        tick();
        check_eq("restart_valid_drop", 32'(recipe_valid), 32'd0);
        check_eq("restart_busy", 32'(busy), 32'd1);
        pulses = 0;
        k = 0;
        while (k < BUDGET) begin
            tick();
            k++;
            if (done) pulses++;
            if (recipe_valid) break;
        end
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) pulses++;
        end
        check_eq("held_start_pulses", 32'(pulses), 32'd1);
        check_eq("held_start_count", 32'(layer_count), 32'(N));

        // Abort with reset once three layers are in.
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (k < BUDGET && layer_count != 3'd3) begin
            tick();
            k++;
        end
        check_eq("reach_cnt3", 32'(layer_count), 32'd3);
        resetn = 1'b0;
        tick();
        check_eq("abort_recipe", 32'(recipe), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        run_to_done(k);
        check_eq("reseed_after_reset", 32'(recipe), 32'(18'o712412));

        // Zero seed is replaced by 1: layers 2,4,0,1,3.
        seed_ld = 1'b1;
        seed_in = 8'h00;
        tick();
        seed_ld = 1'b0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        run_to_done(k);
        check_eq("seed0_latency", 32'(k), 32'd5);
        check_eq("seed0_recipe", 32'(recipe), 32'(18'o724013));

        // Randomized traffic: starts, reseeds (including zero) and occasional resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            start   = ($urandom_range(0, 7) == 0);
            seed_ld = ($urandom_range(0, 15) == 0);
            seed_in = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            resetn  = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
